// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame constants, line defaults and parity helper.
package uart_pkg;

    localparam int CLK_HZ_DEF     = 24000000;
    localparam int BAUD_DEF       = 9600;
    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS      = 8;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    // Parity bit the transmitter puts on the line for a given byte and mode.
    function automatic logic expected_parity(input logic [DATA_BITS-1:0] data, input logic odd_sel);
        return (^data) ^ odd_sel;
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick divider: one-cycle tick every TICK_DIV clocks, held at zero while clr is high.
module uart_rx_tick #(
    parameter int TICK_DIV = 156
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == LAST) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit, 16x oversampled.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = CLK_HZ_DEF,
    parameter int BAUD       = BAUD_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       Parity_sel,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int TICK_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam logic [3:0] MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST = 4'(OVERSAMPLE - 1);

    logic [1:0] sync_q, sync_d;
    logic       rx_prev_q, rx_prev_d;
    logic [2:0] state_q, state_d;
    logic [3:0] samp_q, samp_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       par_sel_q, par_sel_d;
    logic       par_mis_q, par_mis_d;
    logic       stop_bit_q, stop_bit_d;
    logic       stop_done_q, stop_done_d;
    logic       busy_q, busy_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;

    logic rx_s;
    logic fall_s;
    logic tick_s;

    assign rx_s   = sync_q[1];
    assign fall_s = rx_prev_q & ~rx_s;

    uart_rx_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == ST_IDLE),
        .tick (tick_s)
    );

    // Next-state logic for synchronizer, frame FSM, shifter and reported results.
    always_comb begin
        sync_d      = {sync_q[0], rx};
        rx_prev_d   = rx_s;
        state_d     = state_q;
        samp_d      = samp_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        par_sel_d   = par_sel_q;
        par_mis_d   = par_mis_q;
        stop_bit_d  = stop_bit_q;
        stop_done_d = stop_done_q;
        busy_d      = busy_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        case (state_q)
            ST_IDLE: begin
                if (fall_s) begin
                    state_d = ST_START;
                    samp_d  = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && (samp_q == MID)) begin
                    samp_d = 4'd0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        par_sel_d = Parity_sel;
                        busy_d    = 1'b1;
                        bit_idx_d = 3'd0;
                        state_d   = ST_DATA;
                    end
                end else if (tick_s) begin
                    samp_d = samp_q + 4'd1;
                end else begin
                    samp_d = samp_q;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    samp_d = samp_q + 4'd1;
                    if (samp_q == LAST) begin
                        shift_d   = {rx_s, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = ST_PARITY;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end else begin
                    samp_d = samp_q;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    samp_d = samp_q + 4'd1;
                    if (samp_q == LAST) begin
                        par_mis_d   = rx_s ^ expected_parity(shift_q, par_sel_q);
                        stop_done_d = 1'b0;
                        state_d     = ST_STOP;
                    end else begin
                        state_d = ST_PARITY;
                    end
                end else begin
                    samp_d = samp_q;
                end
            end
            ST_STOP: begin
                // Results are published one clock after the stop sample is taken.
                if (stop_done_q) begin
                    data_d      = shift_q;
                    valid_d     = 1'b1;
                    perr_d      = par_mis_q;
                    ferr_d      = ~stop_bit_q;
                    stop_done_d = 1'b0;
                    if (stop_bit_q) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_BREAK;
                    end
                end else if (tick_s) begin
                    samp_d = samp_q + 4'd1;
                    if (samp_q == LAST) begin
                        stop_bit_d  = rx_s;
                        stop_done_d = 1'b1;
                    end else begin
                        stop_done_d = 1'b0;
                    end
                end else begin
                    samp_d = samp_q;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; synchronizer idles high to avoid a false start after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= 2'b11;
            rx_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            samp_q      <= 4'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_sel_q   <= 1'b0;
            par_mis_q   <= 1'b0;
            stop_bit_q  <= 1'b1;
            stop_done_q <= 1'b0;
            busy_q      <= 1'b0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            rx_prev_q   <= rx_prev_d;
            state_q     <= state_d;
            samp_q      <= samp_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            par_sel_q   <= par_sel_d;
            par_mis_q   <= par_mis_d;
            stop_bit_q  <= stop_bit_d;
            stop_done_q <= stop_done_d;
            busy_q      <= busy_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
RS-232 receiver at 9600 baud, the counterpart of the existing transmitter: 8 data bits LSB first, 1 parity bit (even/odd selectable), 1 stop bit.
- Oversamples the line at 16x from the 24 MHz system clock and recovers bytes.
- Flags parity and framing errors.
- Presents each byte with a single-cycle valid strobe to the downstream consumer (MIPS bus interface or loopback checker).

Parameters:
CLK_HZ, 24000000, system clock frequency in Hz
BAUD, 9600, line bit rate
OVERSAMPLE, 16, samples per bit period; must be even
TICK_DIV, CLK_HZ/(BAUD*OVERSAMPLE) = 156 (integer truncation), clk cycles per oversample tick

Ports:
clk  input  1  system clock, 24 MHz, all logic on rising edge
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
Parity_sel  input  1  0 = even parity, 1 = odd parity; latched at start-bit confirmation
data_out  output  8  last received byte, held until the next frame completes
data_valid  output  1  one-clk pulse when data_out/parity_err/frame_err update
parity_err  output  1  parity mismatch on the frame reported by data_valid; held
frame_err  output  1  stop bit sampled low on the frame reported by data_valid; held
busy  output  1  high from start-bit confirmation until return to IDLE

Behaviour:
- Reset values: data_out=8'h00, data_valid=0, parity_err=0, frame_err=0, busy=0, FSM=IDLE. Synchronizer FFs reset to 1. Tick divider and counters reset to 0.
- Reset asserted mid-frame aborts immediately; no data_valid is produced for the partial frame.
- rx passes through a 2-FF synchronizer; rx_s denotes the synchronized level. All decisions use rx_s.
- Tick generator:
  - Counts 0..TICK_DIV-1 and emits a 1-clk tick on wrap.
  - Held at 0 in IDLE; restarts from 0 on the falling edge of rx_s, so bit centers align to the edge.
- Sample counter: 4 bits, counts ticks within a bit, wraps 15->0.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on rx_s 1->0, go to START and clear the sample counter.
  - START: at tick 7 (mid-bit):
    - rx_s=1 -> false start, back to IDLE, busy stays 0.
    - rx_s=0 -> latch Parity_sel, busy=1, clear bit index, go to DATA.
  - DATA: every 16 ticks after the mid-start sample, shift rx_s into the shift register at bit index 0..7 (LSB first). After index 7, go to PARITY.
  - PARITY: sample at mid-bit. Compute expected = XOR of the 8 data bits XOR latched Parity_sel. Record mismatch.
  - STOP: sample at mid-bit. On the following clk:
    - data_out <= shift register, data_valid=1 for exactly one cycle.
    - parity_err <= mismatch; frame_err <= (stop sample == 0).
    - If stop=1, go to IDLE with busy=0; a new falling edge is accepted on the very next cycle.
    - If stop=0, go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE with busy=0. No further data_valid until a new start is confirmed.
- Latency, start edge at rx pin to data_valid: 2 (sync) + 8+16*10 = 168 ticks x 156 clk + 1 = 26211 clk (±1 for synchronizer phase).
- Rx edges inside a frame are ignored; only mid-bit samples matter.
- No input backpressure: an unread byte is overwritten by the next frame.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (3-bit localparams IDLE..BREAK).
  - DATA_BITS=8 and PARITY_EVEN=0/PARITY_ODD=1 constants.
  - Default CLK_HZ/BAUD/OVERSAMPLE, reused by the transmitter side.
- One sub-module, uart_rx_tick:
  - Parameterized TICK_DIV divider with synchronous clear (held in IDLE / restart on edge).
  - Output: tick.
- Synchronizer, FSM, shift register and parity logic stay in uart_rx.

Test Plan:
- Even parity, 0xA5: drive 0xA5 with parity 0 and stop 1 at 9600 baud, Parity_sel=0 -> one data_valid pulse, data_out=8'hA5, parity_err=0, frame_err=0, busy falls the same cycle the FSM enters IDLE.
- Odd parity, 0x00: drive 0x00 with parity bit 1, Parity_sel=1 -> data_out=8'h00, parity_err=0. Resend the same frame with parity bit 0 -> parity_err=1, data_out=8'h00.
- Framing error and break: drive 0x3C with the stop bit low, then hold rx low for 3 bit times -> data_valid once, data_out=8'h3C, frame_err=1. No second valid during the low period. After rx returns high, frame 0x55 -> data_out=8'h55, frame_err=0.
- Glitch rejection: rx low for 4 ticks (624 clk), then high -> no data_valid, busy stays 0, FSM back in IDLE.
- Reset mid-frame: assert rst during bit 4 of 0xFF -> all outputs 0 immediately. Release rst, then send 0x81 -> data_out=8'h81 with exactly one valid pulse.
- Back-to-back with baud skew: frames 0x12, 0x34, 0xFE with zero idle gap at +2% and -2% baud -> three valid pulses with correct data and no errors.
